csa_accumulator: RTL and testbench

CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

---
 rtl/csa_accumulator_if.sv | 26 ++
 rtl/csa_accumulator.sv | 66 ++++++
 tb/tb_csa_accumulator.sv | 129 ++++++++++++
 3 files changed

// File: rtl/csa_accumulator_if.sv
// csa_accumulator_if: operand stream in, packet result out
// Ports (slave view): in_valid/in_data/in_last/out_ready in;
//   in_ready/out_valid/out_sum/out_ovf/out_count out
interface csa_accumulator_if #(
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 16,
   parameter int CNT_WIDTH = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_data;
   logic                 in_last;
   logic                 out_valid;
   logic                 out_ready;
   logic [ACC_WIDTH-1:0] out_sum;
   logic                 out_ovf;
   logic [CNT_WIDTH-1:0] out_count;
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf, out_count
   );
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_ovf, out_count
   );
endinterface

// File: rtl/csa_accumulator.sv
// csa_accumulator: carry-save packet accumulator with one-cycle carry resolve
// Ports: clk, rst (sync, active-high); bus (slave) carries the operand
//   stream handshake and the held result handshake
module csa_accumulator #(
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 16,
   parameter int CNT_WIDTH = 8
) (
   input logic               clk,
   input logic               rst,
   csa_accumulator_if.slave  bus
);
   typedef enum logic [1:0] {ACCUM, RESOLVE, HOLD} state_t;
   state_t               r_state, w_next;
   logic [ACC_WIDTH-1:0] r_s, r_c, w_x, w_maj, r_sum;
   logic [ACC_WIDTH:0]   w_full;
   logic [CNT_WIDTH-1:0] r_cnt, r_count;
   logic                 r_k, r_ovf, w_accept;
   assign w_x      = ACC_WIDTH'(bus.in_data);
   assign w_maj    = (r_s & r_c) | (r_s & w_x) | (r_c & w_x);
   assign w_full   = {1'b0, r_s} + {1'b0, r_c};
   assign w_accept = bus.in_valid && r_state == ACCUM;
   assign bus.in_ready  = r_state == ACCUM;
   assign bus.out_valid = r_state == HOLD;
   assign bus.out_sum   = r_sum;
   assign bus.out_ovf   = r_ovf;
   assign bus.out_count = r_count;
   always_comb begin
      w_next = r_state;
      w_next = r_state == ACCUM   ? ((w_accept && bus.in_last) ? RESOLVE : ACCUM) :
               r_state == RESOLVE ? HOLD :
               (bus.out_ready ? ACCUM : HOLD);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ACCUM;
         r_s     <= '0;
         r_c     <= '0;
         r_k     <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_ovf   <= 1'b0;
         r_count <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_s   <= r_s ^ r_c ^ w_x;
            // top majority bit would carry into weight 2^ACC_WIDTH: remember it
            r_c   <= w_maj << 1;
            r_k   <= r_k | w_maj[ACC_WIDTH-1];
            r_cnt <= r_cnt + CNT_WIDTH'(r_cnt != '1);
         end
         if (r_state == RESOLVE) begin
            r_sum   <= w_full[ACC_WIDTH-1:0];
            r_ovf   <= r_k | w_full[ACC_WIDTH];
            r_count <= r_cnt;
         end
         if (r_state == HOLD && bus.out_ready) begin
            r_s   <= '0;
            r_c   <= '0;
            r_k   <= 1'b0;
            r_cnt <= '0;
         end
      end
   end
endmodule

// File: tb/tb_csa_accumulator.sv
// tb_csa_accumulator: directed and randomized checks of csa_accumulator
module tb_csa_accumulator;
   logic clk = 1'b0;
   logic rst;
   int   n_pass = 0;
   int   n_tot  = 0;
   always #5 clk = ~clk;
   csa_accumulator_if bus ();
   csa_accumulator_if #(.WIDTH(4), .ACC_WIDTH(4), .CNT_WIDTH(8)) bus4 ();
   csa_accumulator u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
   csa_accumulator #(.WIDTH(4), .ACC_WIDTH(4), .CNT_WIDTH(8)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask
   task automatic push(input int d, input bit l);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(d);
      bus.in_last  = l;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask
   task automatic rand_pkt();
      int  n, d;
      longint exp;
      n   = $urandom_range(1, 8);
      exp = 0;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            bus.in_last  = 1'($urandom);
            @(negedge clk);
         end
         d = $urandom_range(0, 255);
         exp += d;
         push(d, i == n - 1);
      end
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'($urandom);
      bus.in_last   = 1'b1;
      bus.out_ready = 1'b0;
      chk("rnd_ready_resolve", 32'(bus.in_ready), 0);
      @(negedge clk);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      chk("rnd_sum", 32'(bus.out_sum), 32'(exp % 65536));
      chk("rnd_ovf", 32'(bus.out_ovf), 32'(exp >= 65536));
      chk("rnd_count", 32'(bus.out_count), 32'(n));
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask
   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
      bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_last = 1'b0; bus4.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_sum", 32'(bus.out_sum), 0);
      chk("rst_out_count", 32'(bus.out_count), 0);
      chk("rst_out_ovf", 32'(bus.out_ovf), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      chk("rst_in_ready4", 32'(bus4.in_ready), 1);
      push(3, 0); push(5, 0); push(7, 0); push(9, 1);
      chk("basic_valid_c1", 32'(bus.out_valid), 0);
      chk("basic_ready_c1", 32'(bus.in_ready), 0);
      @(negedge clk);
      chk("basic_valid_c2", 32'(bus.out_valid), 1);
      chk("basic_sum", 32'(bus.out_sum), 24);
      chk("basic_ovf", 32'(bus.out_ovf), 0);
      chk("basic_count", 32'(bus.out_count), 4);
      @(negedge clk);
      chk("basic_valid_after", 32'(bus.out_valid), 0);
      chk("basic_ready_after", 32'(bus.in_ready), 1);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 300; i++) push(255, i == 299);
      @(negedge clk);
      chk("sat_valid", 32'(bus.out_valid), 1);
      chk("sat_sum", 32'(bus.out_sum), 10964);
      chk("sat_ovf", 32'(bus.out_ovf), 1);
      chk("sat_count", 32'(bus.out_count), 255);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      push(255, 1);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", 32'(bus.out_valid), 1);
         chk("hold_sum", 32'(bus.out_sum), 255);
         chk("hold_ready", 32'(bus.in_ready), 0);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("release_ready", 32'(bus.in_ready), 1);
      chk("release_valid", 32'(bus.out_valid), 0);
      push(10, 0); push(20, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_sum", 32'(bus.out_sum), 0);
      push(1, 1);
      @(negedge clk);
      chk("midrst_valid", 32'(bus.out_valid), 1);
      chk("midrst_sum1", 32'(bus.out_sum), 1);
      chk("midrst_count", 32'(bus.out_count), 1);
      chk("midrst_ovf", 32'(bus.out_ovf), 0);
      @(negedge clk);
      bus4.in_valid = 1'b1; bus4.in_data = 4'd15; bus4.in_last = 1'b0;
      @(negedge clk);
      bus4.in_data = 4'd1; bus4.in_last = 1'b1;
      @(negedge clk);
      bus4.in_valid = 1'b0; bus4.in_last = 1'b0;
      @(negedge clk);
      chk("w4_valid", 32'(bus4.out_valid), 1);
      chk("w4_sum", 32'(bus4.out_sum), 0);
      chk("w4_ovf", 32'(bus4.out_ovf), 1);
      chk("w4_count", 32'(bus4.out_count), 2);
      @(negedge clk);
      for (int p = 0; p < 1000; p++) rand_pkt();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
